xyolo_ctrl: RTL and testbench
=============================

// Module: xyolo_ctrl
// PURPOSE
//  Sequencer for one xyolo MAC/activation/maxpool datapath. Runs a layer pass of N output windows of K MACs each.
//  Generates operand addresses, ld_acc/ld_res/ld_mp strobes and the static config bits, aligned to datapath latency.
//  Sits between the layer config registers (written by CPU) and the xyolo datapath and its operand memories.
// PARAMETERS
//  ADDR_W   10  width of pixel/weight address outputs
//  CNT_W    16  width of window count and MAC count
//  MUL_LAT  4   multiplier pipeline depth, in cycles from operand issue to dsp_out valid
//  SHIFT_W  5   width of the shift field
// PORTS
//  clk           in   1        clock
//  rst           in   1        async reset, active-high
//  run           in   1        start pulse; config is sampled on this cycle
//  cfg_ker_len   in   CNT_W    MACs per window (K)
//  cfg_n_win     in   CNT_W    windows per pass (N)
//  cfg_px_base   in   ADDR_W   pixel address of window 0, MAC 0
//  cfg_px_stride in   ADDR_W   pixel address step between windows
//  cfg_bias/leaky/sigmoid/maxpool/bypass  in 1 each  layer mode bits
//  cfg_shift     in   SHIFT_W  fixed-point shift
//  px_addr       out  ADDR_W   pixel memory address; data arrives on flow_in_pixel at the issue cycle
//  w_addr        out  ADDR_W   weight memory address (= MAC index k)
//  ld_acc, ld_res, ld_mp  out 1  datapath strobes
//  bias, leaky, sigmoid, maxpool, bypass  out 1  registered copies of the cfg bits
//  shift         out  SHIFT_W  registered copy of cfg_shift
//  out_valid     out  1        flow_out holds a finished output this cycle
//  busy          out  1        a pass is in progress
//  done          out  1        1-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE; delay line is cleared. Reset mid-pass aborts the pass with no done pulse.
//  FSM: IDLE -run-> ISSUE -last MAC of last window issued-> DRAIN -delay line empty-> IDLE with done=1 for 1 cycle.
//    If N==0 or (K==0 and !bypass): IDLE -run-> DONE (1 cycle) -> IDLE. No strobes are issued.
//  run while busy is ignored. Cfg outputs are held from the run cycle until the next run.
//  ISSUE: one MAC per cycle, no bubbles between windows.
//    px_addr = px_base + w*px_stride + k; w_addr = k; k wraps at K-1; w increments on wrap.
//    ld_acc=1 on k==0, which loads bias<<shift (or 0), else accumulates.
//    bypass: K is ignored; one issue per window (k=0); px_addr = px_base + w*px_stride.
//  Result delay D from the last-MAC issue cycle to ld_res:
//    D = MUL_LAT if leaky; MUL_LAT+1 otherwise (registered shift/sigmoid path); 1 if bypass.
//    Implemented as a tag delay line of depth MUL_LAT+1; tag = {last_of_window, grp_first, grp_last}.
//  ld_res: 1-cycle pulse per window at issue_last + D.
//  Maxpool groups of 4 consecutive windows:
//    ld_mp=0 with the first ld_res of a group (loads); ld_mp=1 with the next 3 (max).
//    maxpool=0: ld_mp is always 0.
//  out_valid: 1 cycle after the ld_res of every window (maxpool=0),
//    or after the 4th ld_res of a group, or after the final window if N%4 != 0 (partial group flushed).
//  done: asserted the cycle after the final out_valid; busy falls together with done.
//  Address arithmetic is modulo 2^ADDR_W (wrap allowed, no error).
// CONFIGURATION
//  XYOLO_CTRL_PERF_EN defined:
//    adds output perf_cycles [31:0]: cleared on run, +1 each busy cycle, held after done, saturates at all-ones.
//  Undefined: the port and the counter are absent.
// STRUCTURE
//  xyolo_ctrl.vh: FSM state encodings (IDLE, ISSUE, DRAIN, DONE), tag bit indices, MP_GROUP=4.
//  Sub-module xyolo_ctrl_dly: parameterised tag shift register, with variable tap select for D.
//  Address/counter logic and the FSM stay in xyolo_ctrl.
// TESTING (MUL_LAT=4, with a xyolo datapath model attached)
//  K=3,N=2,leaky=1,run@t0 -> ld_acc @t1,t4; ld_res @t7,t10; out_valid @t8,t11; done @t12.
//  K=3,N=2,leaky=0 -> ld_res @t8,t11; flow_out equals golden shift/sigmoid result.
//  maxpool=1,K=1,N=6 -> ld_mp pattern 0,1,1,1,0,1; out_valid twice (after windows 4 and 6); flow_out = group max.
//  bypass=1,N=3,px_base=5,px_stride=2 -> px_addr 5,7,9; ld_res 1 cycle after each issue; no ld_acc.
//  N=0 -> done 2 cycles after run, no strobes; run while busy -> ignored; rst mid-ISSUE -> all outputs 0, no done.
//  px_base=1020,px_stride=4,ADDR_W=10 -> px_addr wraps to 0 on the 2nd window.

Source files
------------

// File: rtl/xyolo_ctrl_pkg.sv
// xyolo_ctrl_pkg: shared types for the xyolo layer sequencer.
//   state_e  - sequencer FSM encodings (IDLE, ISSUE, DRAIN, DONE)
//   tag_t    - result tag carried down the latency delay line
//   MP_GROUP - number of consecutive windows reduced by one maxpool
package xyolo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MP_GROUP = 4;

    // last:      this issue was the final MAC of a window (produces ld_res)
    // grp_first: window opens a maxpool group (ld_mp=0 loads)
    // grp_last:  window closes a maxpool group, or is the final window
    typedef struct packed {
        logic last;
        logic grp_first;
        logic grp_last;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/xyolo_ctrl_if.sv
// xyolo_ctrl_if: layer config in, operand addresses / datapath strobes out.
//   master - the sequencer (consumes run/cfg_*, drives addresses and strobes)
//   slave  - config registers + datapath side
interface xyolo_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16,
    parameter int SHIFT_W = 5
);
    logic               run;
    logic [CNT_W-1:0]   cfg_ker_len;
    logic [CNT_W-1:0]   cfg_n_win;
    logic [ADDR_W-1:0]  cfg_px_base;
    logic [ADDR_W-1:0]  cfg_px_stride;
    logic               cfg_bias, cfg_leaky, cfg_sigmoid, cfg_maxpool, cfg_bypass;
    logic [SHIFT_W-1:0] cfg_shift;

    logic [ADDR_W-1:0]  px_addr;
    logic [ADDR_W-1:0]  w_addr;
    logic               ld_acc, ld_res, ld_mp;
    logic               bias, leaky, sigmoid, maxpool, bypass;
    logic [SHIFT_W-1:0] shift;
    logic               out_valid, busy, done;

    modport master (
        input  run, cfg_ker_len, cfg_n_win, cfg_px_base, cfg_px_stride,
               cfg_bias, cfg_leaky, cfg_sigmoid, cfg_maxpool, cfg_bypass, cfg_shift,
        output px_addr, w_addr, ld_acc, ld_res, ld_mp,
               bias, leaky, sigmoid, maxpool, bypass, shift, out_valid, busy, done
    );

    modport slave (
        output run, cfg_ker_len, cfg_n_win, cfg_px_base, cfg_px_stride,
               cfg_bias, cfg_leaky, cfg_sigmoid, cfg_maxpool, cfg_bypass, cfg_shift,
        input  px_addr, w_addr, ld_acc, ld_res, ld_mp,
               bias, leaky, sigmoid, maxpool, bypass, shift, out_valid, busy, done
    );
endinterface

// File: rtl/xyolo_ctrl_dly.sv
// xyolo_ctrl_dly: tag shift register with a run-time tap.
//   clk, rst  - clock, async active-high reset
//   clr_i     - synchronous flush (start of a pass)
//   din_i     - tag entering at the issue cycle
//   tap_i     - stage to read; stage s holds the tag issued s+1 cycles ago
//   dout_o    - selected tag
module xyolo_ctrl_dly #(
    parameter int DEPTH = 5,
    parameter int W     = 3,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [W-1:0]     din_i,
    input  logic [SEL_W-1:0] tap_i,
    output logic [W-1:0]     dout_o
);
    logic [DEPTH-1:0][W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        sr_q <= '0;
        else if (clr_i) sr_q <= '0;
        else            sr_q <= {sr_q[DEPTH-2:0], din_i};
    end

    assign dout_o = sr_q[tap_i];
endmodule

// File: rtl/xyolo_ctrl.sv
// xyolo_ctrl: sequencer for one xyolo MAC/activation/maxpool datapath.
//   clk, rst      - clock, async active-high reset (aborts a pass, no done)
//   bus (master)  - run/cfg_* in; px_addr, w_addr, ld_acc/ld_res/ld_mp,
//                   registered mode bits, out_valid, busy, done out
//   perf_cycles   - busy-cycle counter, only with XYOLO_CTRL_PERF_EN defined
// Runs N windows of K MACs, one MAC per cycle, then drains the result tags
// through the latency delay line before pulsing done.
module xyolo_ctrl
    import xyolo_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16,
    parameter int MUL_LAT = 4,
    parameter int SHIFT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    xyolo_ctrl_if.master bus
`ifdef XYOLO_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_cycles
`endif
);
    localparam int DEPTH = MUL_LAT + 1;
    localparam int SEL_W = $clog2(DEPTH);
    localparam int GRP_W = $clog2(MP_GROUP);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   ker_len_q, n_win_q, k_q, w_q, res_cnt_q;
    logic [ADDR_W-1:0]  row_q, stride_q;
    logic [GRP_W-1:0]   grp_q;
    logic               bias_q, leaky_q, sigmoid_q, maxpool_q, bypass_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               out_valid_q, fin_q, done_q;

    logic               start, empty, issuing, last_mac, last_win, ld_res;
    logic [SEL_W-1:0]   tap;
    tag_t               tag_in, tag_out;

    assign start    = bus.run && (state_q == ST_IDLE);
    assign empty    = (bus.cfg_n_win == '0) || ((bus.cfg_ker_len == '0) && !bus.cfg_bypass);
    assign last_mac = bypass_q || (k_q == ker_len_q - 1'b1);
    assign last_win = (w_q == n_win_q - 1'b1);

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.run) state_d = empty ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (last_mac && last_win) state_d = ST_DRAIN;
            ST_DRAIN: if (fin_q) state_d = ST_IDLE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        issuing     = (state_q == ST_ISSUE);
        bus.busy    = (state_q != ST_IDLE);
        bus.px_addr = issuing ? row_q + ADDR_W'(k_q) : '0;
        bus.w_addr  = issuing ? ADDR_W'(k_q) : '0;
        bus.ld_acc  = issuing && !bypass_q && (k_q == '0);
    end

    // ---- config capture and issue counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ker_len_q <= '0;  n_win_q   <= '0;  stride_q  <= '0;
            bias_q    <= 1'b0; leaky_q  <= 1'b0; sigmoid_q <= 1'b0;
            maxpool_q <= 1'b0; bypass_q <= 1'b0; shift_q   <= '0;
            k_q <= '0; w_q <= '0; row_q <= '0; grp_q <= '0;
        end else if (start) begin
            ker_len_q <= bus.cfg_ker_len;  n_win_q  <= bus.cfg_n_win;
            stride_q  <= bus.cfg_px_stride;
            bias_q    <= bus.cfg_bias;     leaky_q  <= bus.cfg_leaky;
            sigmoid_q <= bus.cfg_sigmoid;  maxpool_q <= bus.cfg_maxpool;
            bypass_q  <= bus.cfg_bypass;   shift_q  <= bus.cfg_shift;
            k_q <= '0; w_q <= '0; row_q <= bus.cfg_px_base; grp_q <= '0;
        end else if (issuing) begin
            if (last_mac) begin
                k_q   <= '0;
                w_q   <= w_q + 1'b1;
                row_q <= row_q + stride_q;   // modulo 2^ADDR_W by truncation
                grp_q <= grp_q + 1'b1;
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // ---- result latency line ----
    assign tag_in.last      = issuing && last_mac;
    assign tag_in.grp_first = (grp_q == '0);
    assign tag_in.grp_last  = (grp_q == GRP_W'(MP_GROUP - 1)) || last_win;

    // Stage s is read s+1 cycles after issue: D=1 bypass, MUL_LAT leaky,
    // MUL_LAT+1 when the registered shift/sigmoid stage is in the path.
    assign tap = bypass_q ? '0 : (leaky_q ? SEL_W'(MUL_LAT - 1) : SEL_W'(MUL_LAT));

    xyolo_ctrl_dly #(.DEPTH(DEPTH), .W(TAG_W), .SEL_W(SEL_W)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .din_i  (tag_in),
        .tap_i  (tap),
        .dout_o (tag_out)
    );

    assign ld_res = tag_out.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            fin_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (start)       res_cnt_q <= '0;
            else if (ld_res) res_cnt_q <= res_cnt_q + 1'b1;
            out_valid_q <= ld_res && (!maxpool_q || tag_out.grp_last);
            // fin_q marks the final out_valid; done follows one cycle later
            fin_q       <= ld_res && (res_cnt_q == n_win_q - 1'b1);
            done_q      <= ((state_q == ST_DRAIN) && fin_q) || (state_q == ST_DONE);
        end
    end

    assign bus.ld_res    = ld_res;
    assign bus.ld_mp     = ld_res && maxpool_q && !tag_out.grp_first;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.bias      = bias_q;
    assign bus.leaky     = leaky_q;
    assign bus.sigmoid   = sigmoid_q;
    assign bus.maxpool   = maxpool_q;
    assign bus.bypass    = bypass_q;
    assign bus.shift     = shift_q;

`ifdef XYOLO_CTRL_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              perf_q <= '0;
        else if (start)                       perf_q <= '0;
        else if (bus.busy && perf_q != '1)    perf_q <= perf_q + 1'b1;
    end
    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_xyolo_ctrl.sv
// tb_xyolo_ctrl: directed checks of xyolo_ctrl strobe timing, addressing,
// maxpool grouping, bypass, empty passes, ignored run and mid-pass reset.
// Per-cycle strobes are captured as bit masks indexed by cycle after run.
module tb_xyolo_ctrl;
    localparam int NCYC = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xyolo_ctrl_if bus ();
`ifdef XYOLO_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    xyolo_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef XYOLO_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] acc_m, res_m, mp_m, ov_m, done_m, busy_m;
    logic [9:0]  px_t [NCYC];
    logic [9:0]  wa_t [NCYC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.px_addr, bus.w_addr, bus.ld_acc, bus.ld_res, bus.ld_mp,
                    bus.bias, bus.leaky, bus.sigmoid, bus.maxpool, bus.bypass,
                    bus.shift, bus.out_valid, bus.busy, bus.done});
    endfunction

    // Pulse run in cycle t0, then record NCYC-1 cycles. inj_at re-pulses run
    // mid-pass (must be ignored); rst_at asserts reset in that cycle.
    task automatic run_pass(input int k, input int n, input int base, input int stride,
                            input logic lk, input logic mp, input logic bp,
                            input int inj_at, input int rst_at);
        bus.cfg_ker_len   = 16'(k);
        bus.cfg_n_win     = 16'(n);
        bus.cfg_px_base   = 10'(base);
        bus.cfg_px_stride = 10'(stride);
        bus.cfg_leaky     = lk;
        bus.cfg_sigmoid   = ~lk;
        bus.cfg_maxpool   = mp;
        bus.cfg_bypass    = bp;
        bus.cfg_bias      = 1'b1;
        bus.cfg_shift     = 5'd7;
        acc_m = '0; res_m = '0; mp_m = '0; ov_m = '0; done_m = '0; busy_m = '0;
        bus.run = 1'b1;
        for (int t = 1; t < NCYC; t++) begin
            @(posedge clk);
            #1;
            bus.run = (t == inj_at);
            if (t == inj_at) bus.cfg_n_win = 16'd9;
            acc_m[t]  = bus.ld_acc;
            res_m[t]  = bus.ld_res;
            mp_m[t]   = bus.ld_mp;
            ov_m[t]   = bus.out_valid;
            done_m[t] = bus.done;
            busy_m[t] = bus.busy;
            px_t[t]   = bus.px_addr;
            wa_t[t]   = bus.w_addr;
            if (t == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_outs", outs(), 64'd0);
                #2;
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        bus.run = 1'b0;
        bus.cfg_ker_len = '0; bus.cfg_n_win = '0;
        bus.cfg_px_base = '0; bus.cfg_px_stride = '0;
        bus.cfg_bias = 1'b0; bus.cfg_leaky = 1'b0; bus.cfg_sigmoid = 1'b0;
        bus.cfg_maxpool = 1'b0; bus.cfg_bypass = 1'b0; bus.cfg_shift = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // K=3 N=2 leaky: D=4
        run_pass(3, 2, 100, 8, 1'b1, 1'b0, 1'b0, -1, -1);
        chk("lk_acc",  acc_m,  64'h12);
        chk("lk_res",  res_m,  64'h480);
        chk("lk_ov",   ov_m,   64'h900);
        chk("lk_done", done_m, 64'h1000);
        chk("lk_busy", busy_m, 64'hFFE);
        chk("lk_mp",   mp_m,   64'h0);
        chk("lk_px",   64'({px_t[1], px_t[3], px_t[4], px_t[6]}), 64'({10'd100, 10'd102, 10'd108, 10'd110}));
        chk("lk_wa",   64'({wa_t[1], wa_t[2], wa_t[5], wa_t[6]}), 64'({10'd0, 10'd1, 10'd1, 10'd2}));
        chk("cfg_hold", 64'({bus.bias, bus.leaky, bus.sigmoid, bus.shift}), 64'({1'b1, 1'b1, 1'b0, 5'd7}));
`ifdef XYOLO_CTRL_PERF_EN
        chk("perf", 64'(perf_cycles), 64'd11);
`endif

        // K=3 N=2 non-leaky: D=5
        run_pass(3, 2, 0, 3, 1'b0, 1'b0, 1'b0, -1, -1);
        chk("nl_res",  res_m,  64'h900);
        chk("nl_ov",   ov_m,   64'h1200);
        chk("nl_done", done_m, 64'h2000);

        // maxpool K=1 N=6 leaky: groups {0..3}, {4,5}
        run_pass(1, 6, 0, 1, 1'b1, 1'b1, 1'b0, -1, -1);
        chk("mp_acc",  acc_m,  64'h7E);
        chk("mp_res",  res_m,  64'h7E0);
        chk("mp_mp",   mp_m,   64'h5C0);
        chk("mp_ov",   ov_m,   64'hA00);
        chk("mp_done", done_m, 64'h1000);

        // bypass N=3 base=5 stride=2 (K ignored)
        run_pass(0, 3, 5, 2, 1'b0, 1'b0, 1'b1, -1, -1);
        chk("bp_px",   64'({px_t[1], px_t[2], px_t[3]}), 64'({10'd5, 10'd7, 10'd9}));
        chk("bp_acc",  acc_m,  64'h0);
        chk("bp_res",  res_m,  64'h1C);
        chk("bp_ov",   ov_m,   64'h38);
        chk("bp_done", done_m, 64'h40);

        // N=0: empty pass
        run_pass(3, 0, 0, 1, 1'b1, 1'b0, 1'b0, -1, -1);
        chk("n0_done", done_m, 64'h4);
        chk("n0_busy", busy_m, 64'h2);
        chk("n0_strb", acc_m | res_m | ov_m, 64'h0);

        // address wrap modulo 1024
        run_pass(2, 2, 1020, 4, 1'b1, 1'b0, 1'b0, -1, -1);
        chk("wrap_px", 64'({px_t[2], px_t[3], px_t[4]}), 64'({10'd1021, 10'd0, 10'd1}));

        // run while busy is ignored
        run_pass(3, 2, 0, 3, 1'b1, 1'b0, 1'b0, 3, -1);
        chk("inj_res",  res_m,  64'h480);
        chk("inj_done", done_m, 64'h1000);

        // reset mid-ISSUE aborts with no done
        run_pass(4, 3, 0, 4, 1'b1, 1'b0, 1'b0, -1, 3);
        chk("rst_done", done_m, 64'h0);
        chk("rst_busy", busy_m, 64'hE);
        chk("rst_res",  res_m | ov_m, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
